// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyph table,
// blank code and the digit-index width helper.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n is the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int digit_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_seg_hex_lut.sv
// Combinational hex nibble to active-low seven-segment code.
module seven_seg_hex_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode seven-segment scanner with tear-free frame updates.
// Optional leading-zero blanking is built when SEVEN_SEG_LZB_EN is defined.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int DW = digit_idx_w(NUM_DIGITS);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]                  p_q, p_d;
    logic [DW-1:0]                  d_q, d_d;
    logic [NUM_DIGITS-1:0][3:0]     pend_val_q, act_val_q;
    logic [NUM_DIGITS-1:0]          pend_dp_q, act_dp_q;
    logic [6:0]                     seg_q, seg_d;
    logic                           dp_q, dp_d;
    logic [NUM_DIGITS-1:0]          an_q, an_d;
    logic                           tick_q;

    logic                           slot_end, frame_end;
    logic [3:0]                     cur_nib;
    logic [6:0]                     lut_seg;
    logic                           blank;

    assign slot_end  = (p_q == P_LAST);
    assign frame_end = slot_end && (d_q == D_LAST);

    always_comb begin
        p_d = slot_end ? '0 : p_q + 1'b1;
        d_d = d_q;
        if (slot_end)
            d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;
    end

    assign cur_nib = act_val_q[d_q];

    seven_seg_hex_lut u_lut (
        .nibble_i (cur_nib),
        .seg_o    (lut_seg)
    );

`ifdef SEVEN_SEG_LZB_EN
    // Highest nonzero nibble; digit 0 is the floor so a zero value still shows "0".
    logic [DW-1:0] msnz;
    always_comb begin
        msnz = '0;
        for (int k = 1; k < NUM_DIGITS; k++)
            if (act_val_q[k] != 4'h0) msnz = DW'(k);
    end
    assign blank = (d_q > msnz);
`else
    assign blank = 1'b0;
`endif

    // First cycle of each slot keeps every anode off so the previous glyph cannot ghost.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (p_q != '0) begin
            an_d[d_q] = 1'b0;
            seg_d     = blank ? SEG_OFF : lut_seg;
            dp_d      = ~act_dp_q[d_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= '0;
            d_q        <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            an_q       <= '1;
            tick_q     <= 1'b0;
        end else begin
            p_q    <= p_d;
            d_q    <= d_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
            tick_q <= frame_end;
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
            end
            // Active only changes between frames; a load on the wrap cycle bypasses pending.
            if (frame_end) begin
                act_val_q <= load ? value : pend_val_q;
                act_dp_q  <= load ? dp_in : pend_dp_q;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule
